ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard. It implements the full request-to-send sequence, bit shifting on device-generated clock edges, odd parity and ACK check. It drives the shared PS/2 clock and data lines open-drain alongside the existing keyboard receiver. `busy` lets the receiver ignore line activity while a transmit is in progress.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, system clock frequency.
- `INHIBIT_US`, 100, time `ps2_clk` is held low before request-to-send.
- `RTS_US`, 5, time both lines are held low before `ps2_clk` is released.
- `TIMEOUT_US`, 2000, maximum gap between device falling edges; also the maximum wait for the first edge.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `tx_data`  in  8  command byte.
- `tx_valid`  in  1  request; accepted when `tx_valid && tx_ready`.
- `tx_ready`  out  1  high only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse: byte sent and ACK received.
- `error`  out  1  one-cycle pulse: timeout or ACK missing.
- `ps2_clk_in`  in  1  raw PS/2 clock pin.
- `ps2_data_in`  in  1  raw PS/2 data pin.
- `ps2_clk_oe`  out  1  1 = pull clock low; 0 = release.
- `ps2_data_oe`  out  1  1 = pull data low; 0 = release.

## Operation
- Cycle counts: `INHIBIT_CYC = CLK_HZ/1_000_000*INHIBIT_US`. `RTS_CYC` and `TIMEOUT_CYC` are derived the same way from `RTS_US` and `TIMEOUT_US`.
- Counter widths are sized with `$clog2` of the largest count.
- Input conditioning: both pins pass through a 2-flop synchronizer. A falling edge is detected as previous synced value 1 and current synced value 0.
- Parity: `par = ~^tx_data` (odd).
- IDLE: both `oe` = 0. On accept, latch `tx_data` and `par`, then go to INHIBIT.
- INHIBIT: `ps2_clk_oe` = 1 for `INHIBIT_CYC` cycles, then go to RTS.
- RTS: `ps2_clk_oe` = 1 and `ps2_data_oe` = 1 (this is the start bit 0) for `RTS_CYC` cycles. Then `ps2_clk_oe` goes to 0, bit index is cleared to 0, and the state goes to SHIFT.
- SHIFT: on each synced falling edge, increment the bit index n and drive the data line as follows:
  - n = 1..8: `ps2_data_oe` = ~`tx_data[n-1]` (LSB first).
  - n = 9: `ps2_data_oe` = ~`par`.
  - n = 10: stop bit, `ps2_data_oe` = 0.
  - n = 11: sample synced data as ACK and go to WAIT_IDLE.
- WAIT_IDLE: wait until synced clock and data are both 1.
  - If the sampled ACK was 0: pulse `done`.
  - If the sampled ACK was 1: pulse `error`.
  - Then go to IDLE.
- Watchdog: a counter runs in SHIFT and WAIT_IDLE and clears on every falling edge. When it reaches `TIMEOUT_CYC`, release both lines, pulse `error` and go to IDLE.
- `tx_valid` while busy is ignored; the byte is not queued.
- `done` and `error` are never high in the same cycle.
- Reset (asynchronous, at any time including mid-SHIFT):
  - state = IDLE, both `oe` = 0, `done` = 0, `error` = 0.
  - `tx_ready` = 1, `busy` = 0.
  - Counters and latched byte cleared.

## Timing
- `tx_ready` falls, and `busy` and `ps2_clk_oe` rise, in the cycle after accept.
- `ps2_clk_oe` stays high for exactly `INHIBIT_CYC + RTS_CYC` cycles.
- `ps2_data_oe` rises after `INHIBIT_CYC` cycles.
- A falling edge on the pin is acted on 3 `clk` cycles later (2 synchronizer stages + 1 edge register). Bit n is therefore driven 3 cycles after pin edge n. This is far inside the device's half-period, which is at least 30 µs.
- `done`/`error` are registered, one cycle wide. `tx_ready` returns to 1 in the cycle after the pulse.
- Back-to-back: a new byte is accepted on the first cycle `tx_ready` = 1 and restarts INHIBIT.

## Structure
- `ps2_pkg`: state enum (IDLE, INHIBIT, RTS, SHIFT, WAIT_IDLE), command constants (`PS2_CMD_SET_LEDS`=8'hED, `PS2_CMD_RESET`=8'hFF, `PS2_BREAK`=8'hF0), `PS2_ACK`=8'hFA, and an odd-parity function.
- Sub-module `ps2_line_sync` provides the 2-flop synchronizer plus falling-edge detect for clock and data. It is reusable by the receiver.

## Test plan
Common bench setup: `CLK_HZ`=1_000_000 (1 cycle/µs). The device model releases its clock at 10 kHz, samples data on rising edges and pulls data low for the ACK.
- Send 0xED → device captures bits 1,0,1,1,0,1,1,1, parity 1, stop 1; ACK given → `done` = 1 for one cycle, `error` = 0, both `oe` = 0. `ps2_clk_oe` measured high for 105 cycles.
- Send 0x00, 0xFF, 0x01 → captured parity 1, 1, 0 respectively; `done` pulses each time.
- Device never clocks after RTS → `error` pulses 2000 cycles after `ps2_clk_oe` falls; both `oe` = 0; `tx_ready` = 1.
- Device omits ACK (data high at edge 11) → `error` = 1, `done` = 0.
- Assert `rst` at bit 4 of SHIFT → both `oe` = 0 in the same cycle (asynchronous), `tx_ready` = 1. After release, 0xF4 sends correctly.
- `tx_valid` with 0x55 held during a transmit of 0xED → only 0xED is observed. 0x55 is accepted once `tx_ready` returns and is sent next with parity 1.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: transmitter states, command bytes, parity helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SHIFT,
        ST_WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_BREAK        = 8'hF0;
    localparam logic [7:0] PS2_ACK          = 8'hFA;

    // Odd parity: the bit that makes the 9-bit total an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte request interface into the PS/2 host transmitter.
// Latency: n/a (wires only).
// Backpressure: valid/ready; tx_ready is high only while the transmitter is idle.
//
// Signals: tx_data/tx_valid from the requester; tx_ready, busy, done, error
// back from the transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, error
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, error
    );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer plus falling-edge detect for the PS/2 clock and data pins.
// Latency: sync outputs 2 clk after the pin; fall flags valid in that same cycle (3rd edge acts).
// Backpressure: none; free-running.
//
// Ports: clk, rst; clk_in/data_in raw pins; clk_sync/data_sync synchronized
// levels; clk_fall/data_fall one-cycle falling-edge flags.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall,
    output logic data_fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;
    logic       data_prev;

    // Reset to 1 (idle bus level) so releasing reset never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_ff    <= 2'b11;
            data_ff   <= 2'b11;
            clk_prev  <= 1'b1;
            data_prev <= 1'b1;
        end else begin
            clk_ff    <= {clk_ff[0], clk_in};
            data_ff   <= {data_ff[0], data_in};
            clk_prev  <= clk_ff[1];
            data_prev <= data_ff[1];
        end
    end

    assign clk_sync  = clk_ff[1];
    assign data_sync = data_ff[1];
    assign clk_fall  = clk_prev & ~clk_ff[1];
    assign data_fall = data_prev & ~data_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11 device-clocked bits, ACK check.
// Latency: busy/clk_oe rise 1 clk after accept; each bit driven 3 clk after the device falling edge.
// Backpressure: tx_ready only in IDLE; a request while busy is ignored, not queued.
//
// Ports: clk, rst (async, active-high); tx (ps2_host_tx_if.slave) carries
// tx_data/tx_valid/tx_ready/busy/done/error; ps2_clk_in/ps2_data_in raw pins;
// ps2_clk_oe/ps2_data_oe open-drain pull-low enables (1 = drive low).
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int INHIBIT_US = 100,
    parameter int RTS_US     = 5,
    parameter int TIMEOUT_US = 2000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);

    localparam int CYC_PER_US  = CLK_HZ / 1_000_000;
    localparam int INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
    localparam int RTS_CYC     = CYC_PER_US * RTS_US;
    localparam int TIMEOUT_CYC = CYC_PER_US * TIMEOUT_US;

    localparam int CNT_MAX_A = (INHIBIT_CYC > RTS_CYC) ? INHIBIT_CYC : RTS_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYC) ? CNT_MAX_A : TIMEOUT_CYC;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Terminal values: a phase of N cycles ends when the counter shows N-1.
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    logic clk_sync;
    logic data_sync;
    logic clk_fall;
    logic data_fall;

    ps2_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .clk_in    (ps2_clk_in),
        .data_in   (ps2_data_in),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fall  (clk_fall),
        .data_fall (data_fall)
    );

    // Data-line edges matter only to the receiver side.
    logic unused_data_fall;
    assign unused_data_fall = data_fall;

    ps2_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;      // phase timer in INHIBIT/RTS, watchdog in SHIFT/WAIT_IDLE
    logic [3:0]     bit_idx_q;    // device falling edges seen so far in SHIFT
    logic [7:0]     byte_q;
    logic           par_q;
    logic           ack_q;        // data level at edge 11; 0 means ACK present
    logic           clk_oe_q;
    logic           data_oe_q;
    logic           done_q;
    logic           error_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            byte_q    <= '0;
            par_q     <= 1'b0;
            ack_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tx.tx_valid) begin
                        byte_q    <= tx.tx_data;
                        par_q     <= odd_parity(tx.tx_data);
                        cnt_q     <= '0;
                        clk_oe_q  <= 1'b1;
                        data_oe_q <= 1'b0;
                        state_q   <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (cnt_q == INH_LAST) begin
                        cnt_q     <= '0;
                        data_oe_q <= 1'b1;  // start bit, held through RTS
                        state_q   <= ST_RTS;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_RTS: begin
                    if (cnt_q == RTS_LAST) begin
                        cnt_q     <= '0;
                        clk_oe_q  <= 1'b0;
                        bit_idx_q <= '0;
                        state_q   <= ST_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_SHIFT: begin
                    // A watchdog error is pulsed while still here so that
                    // tx_ready only returns the cycle after the pulse.
                    if (error_q) begin
                        state_q <= ST_IDLE;
                    end else if (clk_fall) begin
                        cnt_q     <= '0;
                        bit_idx_q <= bit_idx_q + 4'd1;
                        if (bit_idx_q < 4'd8) begin
                            data_oe_q <= ~byte_q[bit_idx_q[2:0]];
                        end else if (bit_idx_q == 4'd8) begin
                            data_oe_q <= ~par_q;
                        end else if (bit_idx_q == 4'd9) begin
                            data_oe_q <= 1'b0;  // stop bit: line released high
                        end else begin
                            ack_q   <= data_sync;
                            state_q <= ST_WAIT_IDLE;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        error_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_WAIT_IDLE: begin
                    if (done_q || error_q) begin
                        state_q <= ST_IDLE;
                    end else if (clk_fall) begin
                        cnt_q <= '0;
                    end else if (clk_sync && data_sync) begin
                        done_q  <= ~ack_q;
                        error_q <= ack_q;
                    end else if (cnt_q == TO_LAST) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        error_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx.tx_ready = (state_q == ST_IDLE);
    assign tx.busy     = (state_q != ST_IDLE);
    assign tx.done     = done_q;
    assign tx.error    = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on an open-drain bus, frames checked against the byte.
// Latency: n/a.
// Backpressure: requests are held until tx_ready.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int CLK_HZ = 1_000_000;
    localparam int INH    = 100;
    localparam int RTS    = 5;
    localparam int TO     = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_host_tx_if tif ();

    logic ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic ps2_clk_line, ps2_data_line;
    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_HZ     (CLK_HZ),
        .INHIBIT_US (INH),
        .RTS_US     (RTS),
        .TIMEOUT_US (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx          (tif),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame as the device should see it on the wire:
    // start 0, eight data bits LSB first, odd parity, stop 1.
    function automatic logic [10:0] expected_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    // Bus monitor, sampled on the falling clk edge.
    int   cyc = 0;
    int   done_cnt = 0, err_cnt = 0, both_hi = 0, ready_hi = 0;
    int   oe_run = 0, last_run = 0, oe_fall_cyc = 0, err_cyc = 0;
    logic pulse_prev = 1'b0, ready_during = 1'b0, ready_after = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tif.done) done_cnt++;
        if (tif.error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (tif.done && tif.error) both_hi++;
        if (tif.tx_ready) ready_hi++;
        if (pulse_prev) ready_after = tif.tx_ready;
        if (tif.done || tif.error) ready_during = tif.tx_ready;
        pulse_prev = tif.done || tif.error;
        if (ps2_clk_oe) begin
            oe_run++;
        end else if (oe_run != 0) begin
            last_run    = oe_run;
            oe_run      = 0;
            oe_fall_cyc = cyc;
        end
    end

    // Present a byte and hold it until accepted; returns one negedge after accept.
    task automatic send_req(input logic [7:0] b, input bit keep_valid);
        int t = 0;
        tif.tx_data  = b;
        tif.tx_valid = 1'b1;
        while (!tif.tx_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        if (!keep_valid) tif.tx_valid = 1'b0;
        check("accept_ready_drop", {31'd0, tif.tx_ready}, 0);
        check("accept_busy", {31'd0, tif.busy}, 1);
        check("accept_clk_oe", {31'd0, ps2_clk_oe}, 1);
    endtask

    // Keyboard model: waits for the host to release clock, then generates
    // nfalls clock pulses, sampling data on each rising edge; pulls data low
    // around pulse 11 when ack is set.
    task automatic dev_xfer(input int nfalls, input bit ack, input int half,
                            output logic [10:0] bits);
        int t = 0;
        bits = '0;
        while (ps2_clk_oe && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("clk_release", {31'd0, ps2_clk_oe}, 0);
        repeat (10) @(negedge clk);
        bits[0] = ps2_data_line;
        for (int i = 1; i <= nfalls; i++) begin
            if (i == 11 && ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i <= 10) bits[i] = ps2_data_line;
            repeat (half) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_pulse(input int base);
        int t = 0;
        while ((done_cnt + err_cnt) == base && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("pulse_seen", {31'd0, (done_cnt + err_cnt) != base}, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_tx(input logic [7:0] b, input bit ack, output logic [10:0] bits);
        int d0 = done_cnt;
        int e0 = err_cnt;
        int half = $urandom_range(30, 60);
        send_req(b, 1'b0);
        dev_xfer(11, ack, half, bits);
        wait_pulse(d0 + e0);
        check("frame", {21'd0, bits}, {21'd0, expected_frame(b)});
        check("done_count", done_cnt - d0, ack ? 1 : 0);
        check("error_count", err_cnt - e0, ack ? 0 : 1);
        check("clk_oe_len", last_run, INH + RTS);
        check("oe_idle", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        check("ready_in_pulse", {31'd0, ready_during}, 0);
        check("ready_after_pulse", {31'd0, ready_after}, 1);
    endtask

    initial begin
        logic [10:0] bits;
        logic [10:0] ref_frame;
        logic [7:0]  b;
        int          d0, e0, r0, t;

        tif.tx_data  = 8'h00;
        tif.tx_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, tif.tx_ready}, 1);
        check("rst_busy", {31'd0, tif.busy}, 0);
        check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        check("rst_pulses", {30'd0, tif.done, tif.error}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Set-LEDs: bits 1,0,1,1,0,1,1,1 then parity 1 and stop 1.
        run_tx(PS2_CMD_SET_LEDS, 1'b1, bits);
        check("ed_data", {24'd0, bits[8:1]}, 32'hED);
        check("ed_parity", {31'd0, bits[9]}, 1);
        check("ed_stop", {31'd0, bits[10]}, 1);

        run_tx(8'h00, 1'b1, bits);
        check("par_00", {31'd0, bits[9]}, 1);
        run_tx(PS2_CMD_RESET, 1'b1, bits);
        check("par_ff", {31'd0, bits[9]}, 1);
        run_tx(8'h01, 1'b1, bits);
        check("par_01", {31'd0, bits[9]}, 0);

        // Device silent after request-to-send: watchdog fires.
        e0 = err_cnt;
        send_req(PS2_BREAK, 1'b0);
        t = 0;
        while (err_cnt == e0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("timeout_seen", err_cnt - e0, 1);
        check("timeout_delay", err_cyc - oe_fall_cyc, TO);
        repeat (2) @(negedge clk);
        check("timeout_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        check("timeout_ready", {31'd0, tif.tx_ready}, 1);

        // Missing ACK.
        run_tx(PS2_ACK, 1'b0, bits);

        // Asynchronous reset in the middle of bit 4.
        send_req(8'hF4, 1'b0);
        dev_xfer(4, 1'b0, 40, bits);
        ref_frame = expected_frame(8'hF4);
        check("mid_partial", {27'd0, bits[4:0]}, {27'd0, ref_frame[4:0]});
        check("mid_data_oe", {31'd0, ps2_data_oe}, {31'd0, ~ref_frame[4]});
        dev_clk_low = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        check("arst_ready", {31'd0, tif.tx_ready}, 1);
        check("arst_busy", {31'd0, tif.busy}, 0);
        @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_tx(8'hF4, 1'b1, bits);

        // Request held during a transmit: only the first byte goes out, the
        // second is taken on the single idle cycle that follows the pulse.
        d0 = done_cnt;
        send_req(PS2_CMD_SET_LEDS, 1'b1);
        tif.tx_data = 8'h55;
        r0 = ready_hi;
        dev_xfer(11, 1'b1, 45, bits);
        check("hold_first_frame", {21'd0, bits}, {21'd0, expected_frame(PS2_CMD_SET_LEDS)});
        wait_pulse(d0 + err_cnt);
        check("hold_done", done_cnt - d0, 1);
        check("hold_ready_cycles", ready_hi - r0, 1);
        check("hold_restarted", {31'd0, tif.busy}, 1);
        tif.tx_valid = 1'b0;
        dev_xfer(11, 1'b1, 45, bits);
        check("hold_second_frame", {21'd0, bits}, {21'd0, expected_frame(8'h55)});
        check("hold_second_par", {31'd0, bits[9]}, 1);
        wait_pulse(d0 + 1 + err_cnt);
        check("hold_done2", done_cnt - d0, 2);

        // Random bytes, device clock rates and ACK presence.
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            run_tx(b, ($urandom_range(0, 3) != 0), bits);
        end

        check("done_error_exclusive", both_hi, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got time %0t", $time);
        $fatal(1);
    end

endmodule
